// File: rtl/alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the sequential ALU:
//   opcode_e  - 4-bit instruction opcodes
//   state_e   - control FSM states (IDLE / ITER / DONE)
//   OPC_MSB/OPC_LSB/DEST_MSB - instruction field positions
//   is_multi() - true for the iterative (multi-cycle) opcodes
// -----------------------------------------------------------------------------
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_AND = 4'h2,
    OP_OR  = 4'h3,
    OP_XOR = 4'h4,
    OP_NOT = 4'h5,
    OP_SHL = 4'h6,
    OP_SHR = 4'h7,
    OP_MUL = 4'h8,
    OP_DIV = 4'h9,
    OP_MOD = 4'hA,
    OP_CMP = 4'hB,
    OP_INC = 4'hC,
    OP_DEC = 4'hD,
    OP_NOP = 4'hE,
    OP_CLR = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Instruction layout: opcode in [15:12], destination starts at bit 11
  // and extends downward by log2(NUM_OUT) bits.
  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 12;
  localparam int DEST_MSB = 11;

  function automatic logic is_multi(input opcode_e op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_seq_iter.sv
// -----------------------------------------------------------------------------
// alu_seq_iter
// Iterative multiply / divide datapath. One iteration per clock while active,
// exactly WIDTH iterations after start.
//   clk, rst      : clock, asynchronous active-low reset
//   start         : load operands and begin (op selects MUL / DIV / MOD)
//   op, a, b      : opcode and operands, sampled on start
//   done          : high on the cycle whose rising edge performs the final
//                   iteration; result/ovf are valid from the following cycle
//                   until the next start
//   result        : MUL low half, DIV quotient or MOD remainder
//   ovf           : MUL nonzero upper half, DIV/MOD divisor was zero
// -----------------------------------------------------------------------------
module alu_seq_iter
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  opcode_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  // hi/lo are shared: {product high, product low} for MUL,
  // {partial remainder, dividend-shifting-into-quotient} for DIV/MOD.
  logic [WIDTH-1:0] hi_q, lo_q, b_q;
  logic [WIDTH-1:0] hi_d, lo_d;
  logic [CW-1:0]    cnt_q;
  logic             active_q, is_mul_q, is_mod_q;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_fits;

  // NOTE: every variable written here gets a value on every path, so no latches.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_fits  = div_shift >= {1'b0, b_q};
    div_diff  = div_shift - {1'b0, b_q};
    // Restoring divide: keep the subtraction only when the divisor fits.
    // With b==0 it always fits, giving all-ones quotient and remainder == a.
    hi_d = div_fits ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    lo_d = {lo_q[WIDTH-2:0], div_fits};
    if (is_mul_q) begin
      // Shift-add: conditionally add b to the high half, then shift right.
      hi_d = mul_sum[WIDTH:1];
      lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  assign done = active_q && (cnt_q == CW'(WIDTH - 1));

  // NOTE: clocked state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      is_mul_q <= 1'b0;
      is_mod_q <= 1'b0;
    end else if (start) begin
      hi_q     <= '0;
      lo_q     <= a;
      b_q      <= b;
      cnt_q    <= '0;
      active_q <= 1'b1;
      is_mul_q <= (op == OP_MUL);
      is_mod_q <= (op == OP_MOD);
    end else if (active_q) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_q + CW'(1);
      if (done) active_q <= 1'b0;
    end
  end

  assign result = is_mul_q ? lo_q : (is_mod_q ? hi_q : lo_q);
  assign ovf    = is_mul_q ? (|hi_q) : (b_q == '0);

endmodule

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
// Sequential ALU with an output register bank. Single-cycle ops commit on the
// accepting edge; MUL/DIV/MOD run WIDTH iterations in alu_seq_iter and commit
// WIDTH+1 edges after acceptance.
//   clk, rst            : clock, asynchronous active-low reset
//   in_valid / in_ready : instruction handshake (ready only in IDLE)
//   instruction         : [15:12] opcode, [11 -: log2(NUM_OUT)] destination
//   data0, data1        : operands A and B
//   out                 : NUM_OUT x WIDTH result registers
//   res_valid           : one-cycle pulse on every commit
//   overflow_flag, zero_flag : flags of the last committed operation
//   busy                : multi-cycle operation in progress (ITER or DONE)
// -----------------------------------------------------------------------------
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int NUM_OUT = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [15:0]                    instruction,
  input  logic [WIDTH-1:0]               data0,
  input  logic [WIDTH-1:0]               data1,
  output logic [NUM_OUT-1:0][WIDTH-1:0]  out,
  output logic                           res_valid,
  output logic                           overflow_flag,
  output logic                           zero_flag,
  output logic                           busy
);

  localparam int DW = $clog2(NUM_OUT);
  localparam int SW = $clog2(WIDTH);

  opcode_e         opc;
  logic [DW-1:0]   dest;
  logic            accept;
  logic            unused_instr;

  assign opc    = opcode_e'(instruction[OPC_MSB:OPC_LSB]);
  assign dest   = instruction[DEST_MSB -: DW];
  assign accept = in_valid && in_ready;
  // Bits below the destination field carry no meaning.
  assign unused_instr = ^instruction[DEST_MSB-DW:0];

  // ---------------------------------------------------------------------------
  // Single-cycle datapath
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]       add_full;
  logic [2*WIDTH-1:0]   shl_full;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_ovf;
  logic                 alu_wr;      // writes out[dest]
  logic                 alu_commit;  // updates flags and pulses res_valid

  assign add_full = {1'b0, data0} + {1'b0, data1};
  // Widened shift so the bits pushed out the top remain visible for overflow.
  assign shl_full = {{WIDTH{1'b0}}, data0} << data1[SW-1:0];

  always_comb begin
    alu_res    = '0;
    alu_ovf    = 1'b0;
    alu_wr     = 1'b1;
    alu_commit = 1'b1;
    case (opc)
      OP_ADD: begin alu_res = add_full[WIDTH-1:0]; alu_ovf = add_full[WIDTH]; end
      OP_SUB: begin alu_res = data0 - data1;       alu_ovf = data0 < data1;   end
      OP_AND: alu_res = data0 & data1;
      OP_OR:  alu_res = data0 | data1;
      OP_XOR: alu_res = data0 ^ data1;
      OP_NOT: alu_res = ~data0;
      OP_SHL: begin alu_res = shl_full[WIDTH-1:0]; alu_ovf = |shl_full[2*WIDTH-1:WIDTH]; end
      OP_SHR: alu_res = data0 >> data1[SW-1:0];
      OP_CMP: begin
        alu_res = data0 - data1;
        alu_ovf = data0 < data1;
        alu_wr  = 1'b0;
      end
      OP_INC: begin alu_res = data0 + WIDTH'(1); alu_ovf = &data0;          end
      OP_DEC: begin alu_res = data0 - WIDTH'(1); alu_ovf = (data0 == '0);   end
      OP_CLR: alu_res = '0;
      // MUL/DIV/MOD commit from the FSM; NOP commits nothing.
      default: begin alu_wr = 1'b0; alu_commit = 1'b0; end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Iterative multiply / divide
  // ---------------------------------------------------------------------------
  logic             iter_done;
  logic [WIDTH-1:0] iter_res;
  logic             iter_ovf;

  alu_seq_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (accept && is_multi(opc)),
    .op     (opc),
    .a      (data0),
    .b      (data1),
    .done   (iter_done),
    .result (iter_res),
    .ovf    (iter_ovf)
  );

  // ---------------------------------------------------------------------------
  // Control FSM, register bank and flags
  // ---------------------------------------------------------------------------
  state_e        state_q;
  logic [DW-1:0] dest_q;

  // NOTE: the register bank is reset like ordinary flops because its cleared contents are visible on out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      dest_q        <= '0;
      in_ready      <= 1'b0;
      busy          <= 1'b0;
      res_valid     <= 1'b0;
      overflow_flag <= 1'b0;
      zero_flag     <= 1'b0;
      out           <= '0;
    end else begin
      res_valid <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // Also raises in_ready on the first edge after reset release.
          in_ready <= 1'b1;
          if (accept) begin
            if (is_multi(opc)) begin
              state_q  <= S_ITER;
              dest_q   <= dest;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end else if (alu_commit) begin
              res_valid     <= 1'b1;
              overflow_flag <= alu_ovf;
              zero_flag     <= (alu_res == '0);
              if (alu_wr) out[dest] <= alu_res;
            end
          end
        end
        S_ITER: begin
          if (iter_done) state_q <= S_DONE;
        end
        S_DONE: begin
          state_q       <= S_IDLE;
          in_ready      <= 1'b1;
          busy          <= 1'b0;
          res_valid     <= 1'b1;
          overflow_flag <= iter_ovf;
          zero_flag     <= (iter_res == '0);
          out[dest_q]   <= iter_res;
        end
        default: begin
          state_q  <= S_IDLE;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
